// File: rtl/half_subtractor_reg.sv
// -----------------------------------------------------------------------------
// half_subtractor_reg
//
// Registered, bit-parallel half subtractor. Each of the WIDTH lanes computes
// a - b on single bits and produces a difference and a borrow. There is no
// borrow chain between lanes; wider subtractors are built above this cell.
// A valid qualifier tracks accepted inputs. A saturating counter records how
// many accepted cycles had at least one lane borrowing.
//
// Parameters
//   WIDTH       number of independent 1-bit lanes (>= 1)
//   CNT_W       width of the borrow-event counter (>= 2)
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   rst_n       synchronous active-low reset; takes priority over all inputs
//   in_valid    a/b are accepted at this edge when high
//   a           minuend bits, one per lane
//   b           subtrahend bits, one per lane
//   cnt_clr     synchronous clear of borrow_cnt (an increment in the same
//               cycle is applied after the clear)
//   d           registered difference per lane (held while in_valid is low)
//   b_out       registered borrow per lane (held while in_valid is low)
//   out_valid   high for exactly one cycle per accepted input
//   borrow_cnt  saturating count of accepted cycles with any lane borrowing
// -----------------------------------------------------------------------------
module half_subtractor_reg #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] b_out,
  output logic             out_valid,
  output logic [CNT_W-1:0] borrow_cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] borrow_s;
  logic             any_borrow_s;
  logic             count_hit_s;
  logic [CNT_W-1:0] cnt_base_s;
  logic [CNT_W-1:0] cnt_next_s;

  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] b_out_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] borrow_cnt_r;

  // Per-lane half subtractor: difference is XOR, borrow when a=0 and b=1.
  always_comb begin
    diff_s       = a ^ b;
    borrow_s     = ~a & b;
    any_borrow_s = |borrow_s;
    count_hit_s  = in_valid & any_borrow_s;
  end

  // Counter next value: clear first, then a saturating increment on top.
  always_comb begin
    cnt_base_s = borrow_cnt_r;
    cnt_next_s = borrow_cnt_r;
    if (cnt_clr) begin
      cnt_base_s = CNT_ZERO;
    end else begin
      cnt_base_s = borrow_cnt_r;
    end
    // CNT_W >= 2 guarantees a cleared counter is never at saturation, so a
    // clear plus a borrow always lands on 1.
    if (count_hit_s && (cnt_base_s != CNT_MAX)) begin
      cnt_next_s = cnt_base_s + CNT_ONE;
    end else begin
      cnt_next_s = cnt_base_s;
    end
  end

  // Result, valid and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_r          <= {WIDTH{1'b0}};
      b_out_r      <= {WIDTH{1'b0}};
      out_valid_r  <= 1'b0;
      borrow_cnt_r <= CNT_ZERO;
    end else begin
      out_valid_r  <= in_valid;
      borrow_cnt_r <= cnt_next_s;
      if (in_valid) begin
        d_r     <= diff_s;
        b_out_r <= borrow_s;
      end else begin
        // Results are held, not cleared, across idle cycles.
        d_r     <= d_r;
        b_out_r <= b_out_r;
      end
    end
  end

  assign d          = d_r;
  assign b_out      = b_out_r;
  assign out_valid  = out_valid_r;
  assign borrow_cnt = borrow_cnt_r;

endmodule

// File: tb/tb_half_subtractor_reg.sv
// -----------------------------------------------------------------------------
// tb_half_subtractor_reg
//
// Drives two instances from one stimulus stream: a 4-lane cell with a 2-bit
// counter (exercises multi-lane and saturation) and a default 1-lane cell with
// a 16-bit counter driven by lane 0. Expected values come from an arithmetic
// reference model: each lane evaluates the integer a-b, the difference bit is
// that value mod 2 and a borrow is a negative result.
// -----------------------------------------------------------------------------
module tb_half_subtractor_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        cnt_clr;

  logic [3:0]  d4;
  logic [3:0]  b_out4;
  logic        out_valid4;
  logic [1:0]  borrow_cnt4;

  logic [0:0]  d1;
  logic [0:0]  b_out1;
  logic        out_valid1;
  logic [15:0] borrow_cnt1;

  int checks_cnt;
  int fail_cnt;

  // reference model state
  int m_d4;
  int m_b4;
  int m_d1;
  int m_b1;
  int m_ov;
  int m_cnt4;
  int m_cnt1;

  half_subtractor_reg #(.WIDTH(4), .CNT_W(2)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cnt_clr   (cnt_clr),
    .d         (d4),
    .b_out     (b_out4),
    .out_valid (out_valid4),
    .borrow_cnt(borrow_cnt4)
  );

  half_subtractor_reg dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a[0:0]),
    .b         (b[0:0]),
    .cnt_clr   (cnt_clr),
    .d         (d1),
    .b_out     (b_out1),
    .out_valid (out_valid1),
    .borrow_cnt(borrow_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model of one clock edge, from the arithmetic meaning of a - b per lane.
  task automatic model_edge(input bit rst, input bit v, input bit clr,
                            input logic [3:0] aa, input logic [3:0] bb);
    int diff;
    bit any4;
    bit any1;
    if (rst) begin
      m_d4 = 0; m_b4 = 0; m_d1 = 0; m_b1 = 0; m_ov = 0; m_cnt4 = 0; m_cnt1 = 0;
    end else begin
      m_ov = v ? 1 : 0;
      any4 = 1'b0;
      any1 = 1'b0;
      if (v) begin
        m_d4 = 0;
        m_b4 = 0;
        for (int i = 0; i < 4; i++) begin
          diff = int'(aa[i]) - int'(bb[i]);
          if (diff % 2 != 0) m_d4 += (1 << i);
          if (diff < 0) begin
            m_b4 += (1 << i);
            any4 = 1'b1;
            if (i == 0) any1 = 1'b1;
          end
        end
        m_d1 = m_d4 % 2;
        m_b1 = m_b4 % 2;
      end
      if (clr) begin
        m_cnt4 = 0;
        m_cnt1 = 0;
      end
      if (v && any4) m_cnt4 = (m_cnt4 + 1 > 3) ? 3 : m_cnt4 + 1;
      if (v && any1) m_cnt1 = (m_cnt1 + 1 > 65535) ? 65535 : m_cnt1 + 1;
    end
  endtask

  // Apply one cycle of stimulus, advance the model and compare after the edge.
  task automatic cyc(input bit rst, input bit v, input bit clr,
                     input logic [3:0] aa, input logic [3:0] bb);
    rst_n    = ~rst;
    in_valid = v;
    cnt_clr  = clr;
    a        = aa;
    b        = bb;
    @(posedge clk);
    model_edge(rst, v, clr, aa, bb);
    #1;
    chk("d4",         int'(d4),          m_d4);
    chk("b_out4",     int'(b_out4),      m_b4);
    chk("out_valid4", int'(out_valid4),  m_ov);
    chk("cnt4",       int'(borrow_cnt4), m_cnt4);
    chk("d1",         int'(d1),          m_d1);
    chk("b_out1",     int'(b_out1),      m_b1);
    chk("out_valid1", int'(out_valid1),  m_ov);
    chk("cnt1",       int'(borrow_cnt1), m_cnt1);
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    checks_cnt = 0;
    fail_cnt   = 0;
    m_d4 = 0; m_b4 = 0; m_d1 = 0; m_b1 = 0; m_ov = 0; m_cnt4 = 0; m_cnt1 = 0;
    rst_n = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0; a = 4'h0; b = 4'h0;

    // Reset held two cycles while inputs request a result.
    cyc(1'b1, 1'b1, 1'b0, 4'h1, 4'h1);
    cyc(1'b1, 1'b1, 1'b0, 4'h1, 4'h1);
    chk("rst_d_const",   int'(d1),          0);
    chk("rst_cnt_const", int'(borrow_cnt1), 0);

    // Truth table on lane 0: 00, 01, 10, 11 back to back.
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("tt00", {int'(d1), int'(b_out1)}, 0);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'h1);
    chk("tt01_d", int'(d1), 1);
    chk("tt01_b", int'(b_out1), 1);
    cyc(1'b0, 1'b1, 1'b0, 4'h1, 4'h0);
    chk("tt10_d", int'(d1), 1);
    chk("tt10_b", int'(b_out1), 0);
    cyc(1'b0, 1'b1, 1'b0, 4'h1, 4'h1);
    chk("tt11_d", int'(d1), 0);
    chk("tt11_b", int'(b_out1), 0);
    chk("tt_cnt", int'(borrow_cnt1), 1);

    // Hold on invalid: results stay put, counter unchanged.
    cyc(1'b0, 1'b1, 1'b0, 4'h1, 4'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h1);
      chk("hold_d", int'(d1), 1);
      chk("hold_ov", int'(out_valid1), 0);
    end

    // Multi-lane pattern.
    cyc(1'b0, 1'b1, 1'b0, 4'b0101, 4'b0011);
    chk("ml_d", int'(d4), 4'b0110);
    chk("ml_b", int'(b_out4), 4'b0010);

    // Clear together with a borrow lands on 1.
    cyc(1'b0, 1'b1, 1'b1, 4'h0, 4'h1);
    chk("clr_inc4", int'(borrow_cnt4), 1);
    chk("clr_inc1", int'(borrow_cnt1), 1);

    // Five borrowing cycles saturate the 2-bit counter at 3.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'hF);
    chk("sat4", int'(borrow_cnt4), 3);
    chk("nosat1", int'(borrow_cnt1), 6);

    // Reset mid-stream discards the pending result.
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'h1);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("mid_ov", int'(out_valid1), 0);
    chk("mid_b", int'(b_out1), 0);
    cyc(1'b0, 1'b1, 1'b0, 4'h1, 4'h1);
    chk("post_ov", int'(out_valid1), 1);
    chk("post_d", int'(d1), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ra = 4'($urandom_range(15, 0));
      rb = 4'($urandom_range(15, 0));
      cyc(($urandom_range(31, 0) == 0), ($urandom_range(3, 0) != 0),
          ($urandom_range(7, 0) == 0), ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/half_subtractor_reg.md
Name: half_subtractor_reg

Overview:
- Registered, bit-parallel half subtractor. Each lane computes the difference and borrow of a − b on single bits.
- Lanes are independent; there is no borrow propagation between lanes.
- Includes a valid qualifier and a saturating borrow-event counter for status/debug.
- Used as a leaf arithmetic cell; a full subtractor or ripple subtractor is built above it.

Parameters:
- WIDTH, 1, number of independent 1-bit subtractor lanes (≥1).
- CNT_W, 16, width of the borrow-event counter (≥2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low; one clock, sampled on rising edge of clk.
- in_valid  input  1  a/b are sampled this cycle when high.
- a  input  WIDTH  minuend bits, one per lane.
- b  input  WIDTH  subtrahend bits, one per lane.
- cnt_clr  input  1  synchronous clear of borrow_cnt.
- d  output  WIDTH  registered difference, per lane.
- b_out  output  WIDTH  registered borrow, per lane.
- out_valid  output  1  high for one cycle per accepted input.
- borrow_cnt  output  CNT_W  saturating count of accepted cycles with any lane borrowing.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - d=0, b_out=0, out_valid=0, borrow_cnt=0.
  - Reset has priority over all other inputs.
- Per-lane function, lane i:
  - d[i] = a[i] XOR b[i].
  - b_out[i] = (NOT a[i]) AND b[i].
- Truth table per lane (a,b -> d,b_out): 00->0,0; 01->1,1; 10->1,0; 11->0,0.
- Latency: exactly 1 clock.
  - If in_valid=1 at edge N, d/b_out reflect that edge's a/b after edge N.
  - out_valid=1 after edge N.
- in_valid=0 at an edge:
  - out_valid=0 after that edge.
  - d and b_out hold their previous values; they are not cleared.
- Back-to-back valid inputs: one result per cycle, no bubbles, no stall. There is no backpressure input.
- borrow_cnt update, evaluated at each non-reset edge:
  - cnt_clr=1: counter becomes 0. If in_valid=1 with a borrow in the same cycle, the counter becomes 1 (the clear applies first, then the increment).
  - Otherwise, if in_valid=1 and any b_out bit of the new result is 1: increment by 1.
  - Saturates at 2^CNT_W−1; does not wrap.
  - Invalid cycles never count.
- Reset asserted mid-stream:
  - Pending result is discarded; out_valid=0 on the next cycle.
  - First post-reset valid input produces a result 1 cycle later as normal.
- Inputs are assumed synchronous to clk; no internal synchronizers.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, a=1, b=1 -> d=0, b_out=0, out_valid=0, borrow_cnt=0 throughout.
- Truth table, WIDTH=1: apply (a,b)=00,01,10,11 on consecutive valid cycles -> one cycle later, (d,b_out) = 00, 11, 10, 00 respectively; out_valid high 4 consecutive cycles; borrow_cnt ends at 1.
- Hold on invalid: valid a=1, b=0 (d=1, b_out=0), then in_valid=0 with a=0, b=1 for 3 cycles -> d stays 1, b_out stays 0, out_valid=0, borrow_cnt unchanged.
- Multi-lane, WIDTH=4: a=4'b0101, b=4'b0011 -> d=4'b0110, b_out=4'b0010; borrow_cnt increments by exactly 1.
- Counter: cnt_clr=1 with in_valid=1, a=0, b=1 -> borrow_cnt=1. With CNT_W=2, 5 borrowing cycles -> borrow_cnt saturates at 3.
- Reset mid-stream: valid a=0, b=1, then rst_n=0 on the next edge -> out_valid=0, d=0, b_out=0. Release reset, apply a=1, b=1 -> d=0, b_out=0, out_valid=1 one cycle later.
